// File: rtl/itof_pipe_if.sv
// itof_pipe_if: valid/ready input and result channels of the integer-to-binary32 converter.
interface itof_pipe_if #(
    parameter int IN_W = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            in_signed;
    logic            in_rm;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic            out_inexact;

    modport master (
        output in_valid, in_data, in_signed, in_rm, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );
    modport slave (
        input  in_valid, in_data, in_signed, in_rm, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );
endinterface

// File: rtl/itof_pipe.sv
// itof_pipe: pipelined integer to binary32 converter, RNE or round-half-up per transaction.
// Steps magnitude/LZC | normalise | round/pack are registered according to STAGES (1..3).
module itof_pipe #(
    parameter int IN_W   = 32,
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    itof_pipe_if.slave bus_io
);
    typedef struct packed {
        logic            neg;
        logic            zero;
        logic            rm;
        logic [IN_W-1:0] mag;
        logic [6:0]      lz;
    } a_t;

    typedef struct packed {
        logic        neg;
        logic        zero;
        logic        rm;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic        guard;
        logic        sticky;
    } b_t;

    function automatic logic [6:0] lzc(input logic [IN_W-1:0] v);
        lzc = 7'(IN_W);
        for (int i = 0; i < IN_W; i++) if (v[i]) lzc = 7'(IN_W - 1 - i);
    endfunction

    function automatic a_t step_a(input logic [IN_W-1:0] d, input logic sgn, input logic rm);
        a_t a;
        a.neg  = sgn & d[IN_W-1];
        a.mag  = a.neg ? -d : d;
        a.zero = ~|a.mag;
        a.rm   = rm;
        a.lz   = lzc(a.mag);
        return a;
    endfunction

    // The leading one is implicit, so only the bits below it are kept; narrow inputs zero-fill.
    function automatic b_t step_b(input a_t a);
        b_t              b;
        logic [IN_W-2:0] nl;
        logic [IN_W+23:0] ext;
        nl       = (IN_W-1)'(a.mag << a.lz);
        ext      = {nl, 25'd0};
        b.neg    = a.neg;
        b.zero   = a.zero;
        b.rm     = a.rm;
        b.exp    = 8'(126 + IN_W - int'(a.lz));
        b.frac   = ext[IN_W+23 -: 23];
        b.guard  = ext[IN_W];
        b.sticky = |ext[IN_W-1:0];
        return b;
    endfunction

    function automatic logic [32:0] step_c(input b_t b);
        logic        up;
        logic [23:0] sum;
        up  = b.guard & (b.rm | b.sticky | b.frac[0]);
        sum = {1'b0, b.frac} + 24'(up);
        return b.zero ? 33'd0 : {b.guard | b.sticky, b.neg, b.exp + 8'(sum[23]), sum[22:0]};
    endfunction

    logic              adv;
    logic [STAGES-1:0] v_q, v_d;
    logic [32:0]       c_q, c_d;
    a_t                a_d, a_s;
    b_t                b_d, b_s;

    assign adv                = bus_io.out_ready | ~v_q[STAGES-1];
    assign bus_io.in_ready    = adv;
    assign bus_io.out_valid   = v_q[STAGES-1];
    assign bus_io.out_data    = c_q[31:0];
    assign bus_io.out_inexact = c_q[32];
    assign v_d                = adv ? STAGES'({v_q, bus_io.in_valid}) : v_q;

    assign a_d = step_a(bus_io.in_data, bus_io.in_signed, bus_io.in_rm);

    generate
        if (STAGES == 3) begin : g_a
            a_t a_q;
            always_ff @(posedge clk or negedge rstn)
                if (!rstn) a_q <= '0;
                else if (adv) a_q <= a_d;
            assign a_s = a_q;
        end else begin : g_a_pass
            assign a_s = a_d;
        end
    endgenerate

    assign b_d = step_b(a_s);

    generate
        if (STAGES >= 2) begin : g_b
            b_t b_q;
            always_ff @(posedge clk or negedge rstn)
                if (!rstn) b_q <= '0;
                else if (adv) b_q <= b_d;
            assign b_s = b_q;
        end else begin : g_b_pass
            assign b_s = b_d;
        end
    endgenerate

    assign c_d = step_c(b_s);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q <= '0;
            c_q <= '0;
        end else begin
            v_q <= v_d;
            if (adv) c_q <= c_d;
        end
    end
endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: table vectors, stall/reset sequences and randomized traffic against a numeric model.
module tb_itof_pipe;
    logic clk = 0;
    logic rstn = 0;
    always #5 clk = ~clk;

    itof_pipe_if #(.IN_W(32)) b ();
    itof_pipe_if #(.IN_W(16)) b16 ();

    itof_pipe #(.IN_W(32), .STAGES(2)) dut   (.clk(clk), .rstn(rstn), .bus_io(b.slave));
    itof_pipe #(.IN_W(16), .STAGES(3)) dut16 (.clk(clk), .rstn(rstn), .bus_io(b16.slave));

    typedef struct {
        logic [31:0] d;
        bit          sg;
        bit          rm;
        logic [31:0] res;
        bit          inx;
    } vec_t;

    int          pass_n = 0;
    int          total_n = 0;
    logic [32:0] exq[$];
    logic [32:0] mon_e;
    bit          hold_prev = 0;
    logic [31:0] data_prev = '0;
    bit          rnd_done = 0;
    vec_t        tbl[11];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Rounds the exact magnitude by integer remainder comparison; returns {inexact, binary32}.
    function automatic logic [32:0] model(input logic [63:0] x, input int w, input bit sg, input bit rm);
        logic [63:0] xm, mag, q, rem, half;
        int p, sh;
        bit neg, up;
        xm  = x & ((64'd1 << w) - 1);
        neg = sg && xm[w-1];
        mag = neg ? (64'd1 << w) - xm : xm;
        if (mag == 0) return '0;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        rem = 0;
        up  = 0;
        if (p <= 23) q = mag << (23 - p);
        else begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            up   = rm ? (rem >= half) : (rem > half || (rem == half && q[0]));
        end
        q = q + 64'(up);
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            p++;
        end
        return {rem != 0, neg, 8'(p + 127), q[22:0]};
    endfunction

    always @(negedge clk) begin
        if (!rstn) hold_prev = 0;
        else begin
            if (hold_prev) check("stall_hold", {b.out_valid, b.out_data}, {1'b1, data_prev});
            hold_prev = b.out_valid & ~b.out_ready;
            data_prev = b.out_data;
            if (b.out_valid && b.out_ready) begin
                if (exq.size() == 0) check("unexpected_out", 64'(b.out_valid), 64'd0);
                else begin
                    mon_e = exq.pop_front();
                    check("result", {b.out_inexact, b.out_data}, mon_e);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] d, input bit sg, input bit rm, input logic [32:0] exp);
        int n = 0;
        b.in_valid  = 1;
        b.in_data   = d;
        b.in_signed = sg;
        b.in_rm     = rm;
        @(negedge clk);
        while (!b.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("accept_timeout", 64'(b.in_ready), 64'd1);
            b.in_valid = 0;
            return;
        end
        exq.push_back(exp);
        @(posedge clk);
        #1 b.in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain", 64'(exq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic conv16(input logic [15:0] d, input bit sg, input bit rm, input logic [32:0] exp);
        b16.in_valid  = 1;
        b16.in_data   = d;
        b16.in_signed = sg;
        b16.in_rm     = rm;
        @(posedge clk);
        #1 b16.in_valid = 0;
        repeat (3) @(negedge clk);
        check("w16_result", {b16.out_valid, b16.out_inexact, b16.out_data}, {1'b1, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        bit sg, rm;
        tbl[0]  = '{32'h0000_0001, 1, 0, 32'h3F80_0000, 0};
        tbl[1]  = '{32'h8000_0000, 1, 0, 32'hCF00_0000, 0};
        tbl[2]  = '{32'hFFFF_FFFF, 1, 0, 32'hBF80_0000, 0};
        tbl[3]  = '{32'hFFFF_FFFF, 0, 0, 32'h4F80_0000, 1};
        tbl[4]  = '{32'h0100_0001, 0, 0, 32'h4B80_0000, 1};
        tbl[5]  = '{32'h0100_0001, 0, 1, 32'h4B80_0001, 1};
        tbl[6]  = '{32'h0100_0003, 0, 0, 32'h4B80_0002, 1};
        tbl[7]  = '{32'h0000_0000, 1, 0, 32'h0000_0000, 0};
        tbl[8]  = '{32'h0000_0000, 0, 1, 32'h0000_0000, 0};
        tbl[9]  = '{32'h8000_0000, 0, 0, 32'h4F00_0000, 0};
        tbl[10] = '{32'h00FF_FFFF, 0, 0, 32'h4B7F_FFFF, 0};

        b.in_valid = 0; b.in_data = 0; b.in_signed = 0; b.in_rm = 0; b.out_ready = 1;
        b16.in_valid = 0; b16.in_data = 0; b16.in_signed = 0; b16.in_rm = 0; b16.out_ready = 1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {b.out_valid, b.out_inexact, b.out_data}, 64'd0);
        check("reset_state16", {b16.out_valid, b16.out_inexact, b16.out_data}, 64'd0);
        @(negedge clk) rstn = 1;
        @(posedge clk);
        #1 check("ready_idle", 64'(b.in_ready), 64'd1);

        send(32'h1, 1, 0, {1'b0, 32'h3F80_0000});
        @(negedge clk) check("latency_early", 64'(b.out_valid), 64'd0);
        @(negedge clk) check("latency_valid", {b.out_valid, b.out_data}, {1'b1, 32'h3F80_0000});
        @(posedge clk);
        #1;
        drain();

        for (int i = 0; i < 11; i++) send(tbl[i].d, tbl[i].sg, tbl[i].rm, {tbl[i].inx, tbl[i].res});
        drain();

        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    d  = $urandom;
                    sg = 1'($urandom);
                    send(d, sg, 0, model(64'(d), 32, sg, 0));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 b.out_ready = 0;
                repeat (3) begin
                    @(negedge clk) check("stall_in_ready", {b.in_ready, b.out_valid}, 64'b01);
                    @(posedge clk);
                end
                #1 b.out_ready = 1;
            end
        join
        drain();

        b.out_ready = 0;
        send(32'd100, 0, 0, model(64'd100, 32, 0, 0));
        send(32'd200, 0, 0, model(64'd200, 32, 0, 0));
        #2 rstn = 0;
        #1 check("rst_async", {b.out_valid, b.out_inexact, b.out_data}, 64'd0);
        exq.delete();
        @(negedge clk);
        @(negedge clk) rstn = 1;
        b.out_ready = 1;
        repeat (5) @(negedge clk) check("no_stale", 64'(b.out_valid), 64'd0);
        @(posedge clk);
        #1 send(32'hFFFF_FF85, 1, 0, model(64'hFFFF_FF85, 32, 1, 0));
        drain();

        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    case ($urandom_range(0, 3))
                        0: d = $urandom;
                        1: d = $urandom_range(0, 255);
                        2: d = (32'd1 << $urandom_range(0, 31)) + $urandom_range(0, 2) - 1;
                        default: d = 32'hFFFF_FFFF - $urandom_range(0, 300);
                    endcase
                    sg = 1'($urandom);
                    rm = 1'($urandom);
                    send(d, sg, rm, model(64'(d), 32, sg, rm));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 b.out_ready = ($urandom_range(0, 3) != 0);
                end
                b.out_ready = 1;
            end
        join
        drain();

        conv16(16'h8000, 1, 0, {1'b0, 32'hC700_0000});
        conv16(16'h8000, 0, 0, {1'b0, 32'h4700_0000});
        for (int i = 0; i < 20; i++) begin
            d  = 32'($urandom_range(0, 65535));
            sg = 1'($urandom);
            rm = 1'($urandom);
            conv16(d[15:0], sg, rm, model(64'(d[15:0]), 16, sg, rm));
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
